// File: rtl/avg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// avg_seq_ctrl
//   Time-multiplexed averaging controller: one shared adder accumulates NSAMP
//   signed samples taken serially, then one shared shifter applies NSHIFT
//   successive right shifts by the frame's captured shift amount. The low
//   DATAWIDTH bits of the result are then offered on a valid/ready output.
//
// Configuration macro:
//   AVG_SEQ_ARITH_SHIFT_EN  defined   -> arithmetic right shift (sign fill)
//                           undefined -> logical right shift (zero fill)
//
// Ports:
//   Clk        in   1          clock, rising edge
//   Rst        in   1          synchronous reset, active-low
//   sa         in   8          shift amount, captured with first sample of a frame
//   in_data    in   DATAWIDTH  signed sample
//   in_valid   in   1          sample valid
//   in_ready   out  1          controller can accept a sample
//   avg_out    out  DATAWIDTH  result, registered
//   out_valid  out  1          avg_out valid
//   out_ready  in   1          consumer accepts result
//   busy       out  1          frame in progress (state != IDLE)
//   dbg_state  out  2          FSM state: 0 IDLE, 1 ACCUM, 2 SHIFT, 3 DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/in_data/sa must be held until accepted; avg_out is
// held stable while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module avg_seq_ctrl #(
   parameter int DATAWIDTH = 16,
   parameter int ACCWIDTH  = 32,
   parameter int NSAMP     = 8,
   parameter int NSHIFT    = 3
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [7:0]           sa,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] avg_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int CNT_W = $clog2(NSAMP);
   localparam int SHC_W = $clog2(NSHIFT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMP - 1);
   localparam logic [SHC_W-1:0] SHC_LAST = SHC_W'(NSHIFT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [ACCWIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SHC_W-1:0]     shcnt_q, shcnt_d;
   logic [7:0]           sa_q, sa_d;
   logic [DATAWIDTH-1:0] avg_q, avg_d;
   logic                 ovalid_q, ovalid_d;

   logic                 accept;
   logic [ACCWIDTH-1:0]  sample_ext;
   logic [ACCWIDTH-1:0]  acc_shifted;

   assign accept     = in_valid & in_ready;
   assign sample_ext = {{(ACCWIDTH - DATAWIDTH){in_data[DATAWIDTH-1]}}, in_data};

   // Shared shifter. Shift amounts at or beyond the accumulator width are
   // resolved explicitly so the fill value never depends on tool behaviour.
`ifdef AVG_SEQ_ARITH_SHIFT_EN
   logic signed [ACCWIDTH-1:0] acc_signed;
   logic signed [ACCWIDTH-1:0] acc_sra;

   always_comb begin
      acc_signed = acc_q;
      // Kept as its own statement so the shift is evaluated in a signed context.
      acc_sra    = acc_signed >>> sa_q;
      if (32'(sa_q) >= ACCWIDTH) begin
         acc_shifted = {ACCWIDTH{acc_q[ACCWIDTH-1]}};
      end else begin
         acc_shifted = acc_sra;
      end
   end
`else
   always_comb begin
      if (32'(sa_q) >= ACCWIDTH) begin
         acc_shifted = '0;
      end else begin
         acc_shifted = acc_q >> sa_q;
      end
   end
`endif

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         shcnt_q  <= '0;
         sa_q     <= '0;
         avg_q    <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         shcnt_q  <= shcnt_d;
         sa_q     <= sa_d;
         avg_q    <= avg_d;
         ovalid_q <= ovalid_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      shcnt_d  = shcnt_q;
      sa_d     = sa_q;
      avg_d    = avg_q;
      ovalid_d = ovalid_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = sample_ext;
               sa_d    = sa;
               cnt_d   = CNT_W'(1);
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               acc_d = acc_q + sample_ext;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  shcnt_d = '0;
                  state_d = S_SHIFT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_SHIFT: begin
            acc_d   = acc_shifted;
            shcnt_d = shcnt_q + SHC_W'(1);
            // The last shift loads the output register directly, so out_valid
            // rises exactly NSHIFT edges after the final sample is taken.
            if (shcnt_q == SHC_LAST) begin
               avg_d    = acc_shifted[DATAWIDTH-1:0];
               ovalid_d = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state. in_ready is gated by Rst so nothing is
   // accepted on an edge that is also resetting the controller.
   always_comb begin
      in_ready  = Rst & ((state_q == S_IDLE) | (state_q == S_ACCUM));
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
      avg_out   = avg_q;
      out_valid = ovalid_q;
   end

endmodule

// File: tb/tb_avg_seq_ctrl.sv
`timescale 1ns/1ps
module tb_avg_seq_ctrl;

   localparam int DW  = 16;
   localparam int AW  = 32;
   localparam int NS  = 8;
   localparam int NSH = 3;

   // ---------------- clock / reset ----------------
   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic [7:0]    sa = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic [DW-1:0] avg_out;
   logic          out_valid;
   logic          busy;
   logic [1:0]    dbg_state;

   always #5 Clk = ~Clk;

   avg_seq_ctrl #(
      .DATAWIDTH(DW), .ACCWIDTH(AW), .NSAMP(NS), .NSHIFT(NSH)
   ) dut (
      .Clk(Clk), .Rst(Rst), .sa(sa), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .avg_out(avg_out), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] model_sum = '0;
   logic signed [AW-1:0] ext;
   int            frame_n = 0;
   int            frame_sa = 0;
   bit            out_pending = 1'b0;
   longint        edge_cnt = 0;
   longint        last_acc_edge = -1;
   logic          prev_ov = 1'b0, prev_hs = 1'b0, prev_rst = 1'b0;
   logic [DW-1:0] prev_avg = '0;
   logic [DW-1:0] last_out = '0;
   bit            rst_check_due = 1'b0;
   bit            rdy_auto = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: wrap-around sum, then NSH shifts by the captured amount.
   function automatic logic [DW-1:0] model_result(input logic [AW-1:0] sum, input int sh);
      logic [AW-1:0] v;
      longint        lv;
      v = sum;
      for (int i = 0; i < NSH; i++) begin
`ifdef AVG_SEQ_ARITH_SHIFT_EN
         if (sh >= AW) begin
            v = v[AW-1] ? '1 : '0;
         end else begin
            lv = $signed(v);
            lv = lv >>> sh;
            v  = lv[AW-1:0];
         end
`else
         if (sh >= AW) v = '0;
         else          v = v >> sh;
`endif
      end
      return v[DW-1:0];
   endfunction

   always @(posedge Clk) edge_cnt++;

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      if (edge_cnt > 0) begin
         if (rst_check_due) begin
            check("rst_avg_out", avg_out, '0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_state", dbg_state, 2'd0);
            rst_check_due = 1'b0;
         end
         check("in_ready", in_ready, Rst && !out_pending);
         check("busy", busy, (frame_n > 0) || out_pending);
         if (out_valid && !prev_ov) begin
            check("latency", 32'(edge_cnt - last_acc_edge), NSH);
         end
         if (prev_ov && !prev_hs && prev_rst) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_avg", avg_out, prev_avg);
         end
         if (out_valid && out_ready && Rst) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               check("avg_out", avg_out, exp_q.pop_front());
            end
            last_out    = avg_out;
            out_pending = 1'b0;
         end
         if (in_valid && in_ready) begin
            if (frame_n == 0) begin
               frame_sa  = int'(sa);
               model_sum = '0;
            end
            ext       = $signed(in_data);
            model_sum = model_sum + ext;
            frame_n++;
            if (frame_n == NS) begin
               exp_q.push_back(model_result(model_sum, frame_sa));
               frame_n       = 0;
               out_pending   = 1'b1;
               last_acc_edge = edge_cnt + 1;
            end
         end
         if (!Rst) begin
            frame_n       = 0;
            out_pending   = 1'b0;
            exp_q.delete();
            rst_check_due = 1'b1;
         end
      end
      prev_ov  = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_rst = Rst;
      prev_avg = avg_out;
   end

   // ---------------- drivers ----------------
   initial forever begin
      @(posedge Clk);
      #1;
      if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [DW-1:0] d, input logic [7:0] s, input int gap);
      int   t;
      logic ok;
      t        = 0;
      in_data  = d;
      sa       = s;
      in_valid = 1'b1;
      forever begin
         @(negedge Clk);
         ok = in_ready;
         @(posedge Clk);
         #1;
         if (ok) break;
         t++;
         if (t > 300) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] first, input logic [DW-1:0] step,
                             input logic [7:0] s, input int gap);
      for (int i = 0; i < NS; i++) send(first + step * DW'(i), s, gap);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      forever begin
         @(negedge Clk);
         if (!busy && !out_pending) break;
         t++;
         if (t > 300) begin
            check("idle_timeout", 0, 1);
            break;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] rs;
      int         r;
      Rst = 1'b0;
      cycles(3);
      Rst = 1'b1;
      cycles(2);

      // 1: sa=1, samples 1..8 back-to-back
      rdy_auto  = 1'b0;
      out_ready = 1'b1;
      send_frame(16'd1, 16'd1, 8'd1, 0);
      wait_idle();
      check("t1_avg", last_out, 16'h0004);

      // 2: sa=8, eight samples of -16
      send_frame(16'hFFF0, 16'd0, 8'd8, 0);
      wait_idle();
`ifdef AVG_SEQ_ARITH_SHIFT_EN
      check("t2_avg", last_out, 16'hFFFF);
`else
      check("t2_avg", last_out, 16'h00FF);
`endif

      // 3: sa=0 and sa=40 with 0x7FFF samples
      send_frame(16'h7FFF, 16'd0, 8'd0, 0);
      wait_idle();
      check("t3_sa0", last_out, 16'hFFF8);
      send_frame(16'h7FFF, 16'd0, 8'd40, 0);
      wait_idle();
      check("t3_sa40", last_out, 16'h0000);

      // 4: consumer stalls 5 cycles on the result
      out_ready = 1'b0;
      send_frame(16'd10, 16'd3, 8'd2, 0);
      for (int t = 0; t < 50 && !out_valid; t++) cycles(1);
      check("t4_valid_seen", out_valid, 1'b1);
      cycles(5);
      out_ready = 1'b1;
      cycles(1);
      out_ready = 1'b0;
      @(negedge Clk);
      check("t4_in_ready_after", in_ready, 1'b1);
      check("t4_state_idle", dbg_state, 2'd0);
      @(posedge Clk);
      #1;
      out_ready = 1'b1;

      // 5: reset after 3 samples, then a clean frame
      send(16'd100, 8'd1, 0);
      send(16'd200, 8'd1, 0);
      send(16'd300, 8'd1, 0);
      Rst = 1'b0;
      cycles(1);
      Rst = 1'b1;
      cycles(1);
      send_frame(16'd1, 16'd1, 8'd1, 0);
      wait_idle();
      check("t5_avg", last_out, 16'h0004);

      // 6: gapped input, sa changes after first sample
      send(16'd1, 8'd1, 2);
      for (int i = 1; i < NS; i++) send(16'(i + 1), 8'd4, 2);
      wait_idle();
      check("t6_avg", last_out, 16'h0004);

      // Random frames with random consumer back-pressure
      rdy_auto = 1'b1;
      for (int f = 0; f < 20; f++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      rs = 8'($urandom_range(0, 4));
         else if (r < 8) rs = 8'($urandom_range(5, 16));
         else            rs = 8'($urandom_range(30, 45));
         for (int i = 0; i < NS; i++) begin
            send(16'($urandom), (i == 0) ? rs : 8'($urandom), $urandom_range(0, 2));
         end
      end
      wait_idle();
      rdy_auto = 1'b0;
      cycles(3);
      check("leftover_expected", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
